// File: rtl/led_pattern_encoder.sv
// led_pattern_encoder
//   Recovers the 0..7 position from an 8-bit one-hot switch/LED pattern.
//   The raw bus is passed through a 2-flop synchroniser. A new value must
//   hold for STABLE_CYCLES clocks before it is accepted and registered.
//   A third register stage holds the previous synchronised value so that
//   changes can be detected.
//
// Optional feature macro: STRICT_ONEHOT_EN
//   defined   : a multi-hot pattern is flagged (err=1, valid=0, number holds)
//   undefined : a multi-hot pattern is priority encoded (highest set bit), err=0
//
// Parameters
//   STABLE_CYCLES : clocks a synchronised value must hold before acceptance (>= 2)
//   CNT_W         : stability counter width, 2**CNT_W > STABLE_CYCLES
//
// Ports
//   clk     in   1  clock, all logic on posedge
//   reset   in   1  synchronous active-low reset
//   pattern in   8  raw asynchronous pattern, bit i = position i
//   number  out  3  accepted index
//   valid   out  1  number reflects an accepted non-empty pattern
//   changed out  1  one-cycle pulse when {valid,number,err} takes a new value
//   err     out  1  multi-hot pattern accepted (STRICT_ONEHOT_EN only)
//
// States
//   state  | meaning
//   IDLE   | after reset, nothing pending, counter held at 0
//   SETTLE | a change was seen, counting stable cycles
//   LOCK   | last value accepted, counter held at 0 until the next change

module led_pattern_encoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pattern,
    output logic [2:0] number,
    output logic       valid,
    output logic       changed,
    output logic       err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       sync_meta, sync, sync_prev;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       number_nxt;
    logic             valid_nxt, err_nxt, changed_nxt;
    logic             sync_change, accept;
    logic [2:0]       hi_idx;
    logic             one_hot;

    // sync_prev lags sync by one clock, so a change is visible for exactly
    // the cycle after the new value reaches the second synchroniser stage.
    assign sync_change = (sync != sync_prev);

    always_comb begin
        hi_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sync[i]) begin
                hi_idx = 3'(i);
            end
        end
    end

    assign one_hot = (sync != 8'd0) && ((sync & (sync - 8'd1)) == 8'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta <= 8'd0;
            sync      <= 8'd0;
            sync_prev <= 8'd0;
            state     <= IDLE;
            cnt       <= '0;
            number    <= 3'd0;
            valid     <= 1'b0;
            err       <= 1'b0;
            changed   <= 1'b0;
        end else begin
            sync_meta <= pattern;
            sync      <= sync_meta;
            sync_prev <= sync;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            number    <= number_nxt;
            valid     <= valid_nxt;
            err       <= err_nxt;
            changed   <= changed_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        number_nxt = number;
        valid_nxt  = valid;
        err_nxt    = err;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (sync_change) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (sync_change) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    accept    = 1'b1;
                    state_nxt = LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            LOCK: begin
                cnt_nxt = '0;
                if (sync_change) begin
                    state_nxt = SETTLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        if (accept) begin
            if (sync == 8'd0) begin
                valid_nxt = 1'b0;
                err_nxt   = 1'b0;
            end else if (one_hot) begin
                number_nxt = hi_idx;
                valid_nxt  = 1'b1;
                err_nxt    = 1'b0;
            end else begin
`ifdef STRICT_ONEHOT_EN
                valid_nxt = 1'b0;
                err_nxt   = 1'b1;
`else
                number_nxt = hi_idx;
                valid_nxt  = 1'b1;
                err_nxt    = 1'b0;
`endif
            end
        end

        changed_nxt = accept &&
                      ({valid_nxt, number_nxt, err_nxt} != {valid, number, err});
    end

endmodule

// File: tb/tb_led_pattern_encoder.sv
module tb_led_pattern_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] pattern;
    logic [2:0] number;
    logic       valid;
    logic       changed;
    logic       err;

    int checks = 0;
    int errors = 0;

    led_pattern_encoder #(
        .STABLE_CYCLES(16),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pattern(pattern),
        .number(number),
        .valid(valid),
        .changed(changed),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance past one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (changed === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        pattern = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({number, valid, changed, err} !== 6'b000_0_0_0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: number=%0d valid=%b changed=%b err=%b, expected 0 0 0 0",
                         i, number, valid, changed, err);
            end
        end
    endtask

    // release reset with 8'h10 applied; first sampled at release edge k
    task automatic test_accept_latency();
        reset   = 1'b1;
        pattern = 8'h10;
        for (int i = 0; i < 18; i++) tick();   // after edge k+17
        checks++;
        if (valid !== 1'b0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid=%b changed=%b at k+17, expected 0 0", valid, changed);
        end
        tick();                                 // after edge k+18
        checks++;
        if ({number, valid, changed, err} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL latency_accept: number=%0d valid=%b changed=%b err=%b, expected 4 1 1 0",
                     number, valid, changed, err);
        end
        tick();
        checks++;
        if (changed !== 1'b0 || number !== 3'd4) begin
            errors++;
            $display("FAIL latency_pulse_width: changed=%b number=%0d, expected 0 4", changed, number);
        end
    endtask

    task automatic test_glitch();
        int p1, p2;
        pattern = 8'h01;
        run_count(15, p1);
        pattern = 8'h10;
        run_count(40, p2);
        checks++;
        if (p1 + p2 !== 0) begin
            errors++;
            $display("FAIL glitch_pulses: changed pulses=%0d, expected 0", p1 + p2);
        end
        checks++;
        if (number !== 3'd4 || valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL glitch_hold: number=%0d valid=%b err=%b, expected 4 1 0", number, valid, err);
        end
    endtask

    task automatic test_wrap();
        int p;
        pattern = 8'h80;
        run_count(30, p);
        checks++;
        if (number !== 3'd7 || valid !== 1'b1 || p !== 1) begin
            errors++;
            $display("FAIL wrap_to7: number=%0d valid=%b pulses=%0d, expected 7 1 1", number, valid, p);
        end
        pattern = 8'h01;
        run_count(30, p);
        checks++;
        if (number !== 3'd0 || valid !== 1'b1 || p !== 1) begin
            errors++;
            $display("FAIL wrap_to0: number=%0d valid=%b pulses=%0d, expected 0 1 1", number, valid, p);
        end
        pattern = 8'h80;
        run_count(30, p);
        checks++;
        if (number !== 3'd7 || valid !== 1'b1 || p !== 1) begin
            errors++;
            $display("FAIL wrap_0to7: number=%0d valid=%b pulses=%0d, expected 7 1 1", number, valid, p);
        end
    endtask

    task automatic test_zero();
        int p;
        pattern = 8'h10;
        run_count(30, p);
        checks++;
        if (number !== 3'd4 || valid !== 1'b1 || p !== 1) begin
            errors++;
            $display("FAIL zero_pre: number=%0d valid=%b pulses=%0d, expected 4 1 1", number, valid, p);
        end
        pattern = 8'h00;
        run_count(30, p);
        checks++;
        if (number !== 3'd4 || valid !== 1'b0 || err !== 1'b0 || p !== 1) begin
            errors++;
            $display("FAIL zero_accept: number=%0d valid=%b err=%b pulses=%0d, expected 4 0 0 1",
                     number, valid, err, p);
        end
    endtask

    task automatic test_multihot();
        int p;
        pattern = 8'h81;
        run_count(30, p);
        checks++;
`ifdef STRICT_ONEHOT_EN
        if (number !== 3'd4 || valid !== 1'b0 || err !== 1'b1 || p !== 1) begin
            errors++;
            $display("FAIL multihot_strict: number=%0d valid=%b err=%b pulses=%0d, expected 4 0 1 1",
                     number, valid, err, p);
        end
`else
        if (number !== 3'd7 || valid !== 1'b1 || err !== 1'b0 || p !== 1) begin
            errors++;
            $display("FAIL multihot_prio: number=%0d valid=%b err=%b pulses=%0d, expected 7 1 0 1",
                     number, valid, err, p);
        end
`endif
        pattern = 8'h24;
        run_count(30, p);
        checks++;
`ifdef STRICT_ONEHOT_EN
        if (number !== 3'd4 || valid !== 1'b0 || err !== 1'b1 || p !== 0) begin
            errors++;
            $display("FAIL multihot2_strict: number=%0d valid=%b err=%b pulses=%0d, expected 4 0 1 0",
                     number, valid, err, p);
        end
`else
        if (number !== 3'd5 || valid !== 1'b1 || err !== 1'b0 || p !== 1) begin
            errors++;
            $display("FAIL multihot2_prio: number=%0d valid=%b err=%b pulses=%0d, expected 5 1 0 1",
                     number, valid, err, p);
        end
`endif
    endtask

    // 8'h04 first sampled at edge k, reset asserted for edge k+10 only
    task automatic test_reset_mid_settle();
        pattern = 8'h04;
        for (int i = 0; i < 10; i++) tick();   // after edge k+9
        reset = 1'b0;
        tick();                                 // edge k+10 applies reset
        checks++;
        if ({number, valid, changed, err} !== 6'b000_0_0_0) begin
            errors++;
            $display("FAIL midreset_clear: number=%0d valid=%b changed=%b err=%b, expected 0 0 0 0",
                     number, valid, changed, err);
        end
        reset = 1'b1;                           // release edge r = k+11
        for (int i = 0; i < 18; i++) tick();   // after edge r+17
        checks++;
        if (valid !== 1'b0 || number !== 3'd0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL midreset_early: number=%0d valid=%b changed=%b at r+17, expected 0 0 0",
                     number, valid, changed);
        end
        tick();                                 // after edge r+18
        checks++;
        if ({number, valid, changed, err} !== {3'd2, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midreset_accept: number=%0d valid=%b changed=%b err=%b, expected 2 1 1 0",
                     number, valid, changed, err);
        end
    endtask

    initial begin
        reset   = 1'b0;
        pattern = 8'h00;
        test_reset();
        test_accept_latency();
        test_glitch();
        test_wrap();
        test_zero();
        test_multihot();
        test_reset_mid_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
